// File: rtl/int_pad_sampler.sv
// ============================================================================
// int_pad_sampler : /NMI, /IRQ, /RES pad synchroniser, optional glitch filter
//                   (INT_PAD_GLITCH_FILTER_EN) and power-on reset stretch.
// Revision 1.0    : initial release
// ============================================================================
`default_nettype none

module int_pad_sampler #(
  parameter int FILTER_CYCLES = 4,
  parameter int POR_CYCLES    = 8
) (
  input  logic PHI0,
  input  logic RST,
  input  logic n_NMI,
  input  logic n_IRQ,
  input  logic n_RES,
  output logic n_NMIP,
  output logic n_IRQP,
  output logic RESP,
  output logic POR_BUSY
);

  localparam int c_NPIN    = 3;
  localparam int c_PIN_NMI = 0;
  localparam int c_PIN_IRQ = 1;
  localparam int c_PIN_RES = 2;

  if ((FILTER_CYCLES < 1) || (FILTER_CYCLES > 16) ||
      (POR_CYCLES < 1) || (POR_CYCLES > 255)) begin : g_param_check
    $error("int_pad_sampler: parameter out of legal range");
  end

  logic [c_NPIN-1:0] w_pad;
  logic [c_NPIN-1:0] s1_q;
  logic [c_NPIN-1:0] s2_q;
  logic [c_NPIN-1:0] f_d;

  assign w_pad = {n_RES, n_IRQ, n_NMI};

  always_ff @(posedge PHI0) begin
    if (RST) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= w_pad;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < c_NPIN; i++) begin : g_pin
`ifdef INT_PAD_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_CYCLES) + 1;

    logic             f_q;
    logic             pin_f_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A return to the accepted level at any point restarts the count.
    always_comb begin
      pin_f_d = f_q;
      cnt_d   = cnt_q;
      if (s2_q[i] == f_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
        pin_f_d = s2_q[i];
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge PHI0) begin
      if (RST) begin
        f_q   <= 1'b1;
        cnt_q <= '0;
      end else begin
        f_q   <= pin_f_d;
        cnt_q <= cnt_d;
      end
    end

    assign f_d[i] = pin_f_d;
`else
    assign f_d[i] = s2_q[i];
`endif
  end

  logic [7:0] por_cnt_q;
  logic [7:0] por_cnt_d;
  logic       por_busy_d;

  always_comb begin
    por_cnt_d = por_cnt_q;
    if (RST) begin
      por_cnt_d = 8'(POR_CYCLES);
    end else if (por_cnt_q != 8'd0) begin
      por_cnt_d = por_cnt_q - 8'd1;
    end
  end

  assign por_busy_d = (por_cnt_d != 8'd0);

  always_ff @(posedge PHI0) begin
    por_cnt_q <= por_cnt_d;
  end

  // Outputs use next-state values so they move on the same edge as the filter.
  always_ff @(posedge PHI0) begin
    if (RST) begin
      n_NMIP   <= 1'b1;
      n_IRQP   <= 1'b1;
      RESP     <= 1'b1;
      POR_BUSY <= 1'b1;
    end else begin
      n_NMIP   <= f_d[c_PIN_NMI] | por_busy_d;
      n_IRQP   <= f_d[c_PIN_IRQ] | por_busy_d;
      RESP     <= por_busy_d | ~f_d[c_PIN_RES];
      POR_BUSY <= por_busy_d;
    end
  end

endmodule

`default_nettype wire
